// File: rtl/cons_bus_arbiter.sv
// Shared-bus arbiter: a host->device load path and a device->host output-descriptor FIFO
// share one bus. A one-cycle turnaround is inserted whenever the bus direction changes.
module cons_bus_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 3
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  ld_req,
  output logic                  ld_grant,
  input  logic                  out_push,
  input  logic [31:0]           out_x,
  input  logic [31:0]           out_y,
  input  logic [31:0]           out_ch,
  input  logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_full,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [31:0]           bus_x,
  output logic [31:0]           bus_y,
  output logic [31:0]           bus_ch,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic                  bus_dir,
  output logic                  overflow_err
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EntW   = 96 + DATA_WIDTH;
  localparam int unsigned BurstW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [CntW-1:0]   AfullLvl  = CntW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0]   FullLvl   = CntW'(FIFO_DEPTH);
  localparam logic [BurstW-1:0] BurstLast = BurstW'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StTurn, StDrain} state_e;

  logic [EntW-1:0]   r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [CntW-1:0]   r_cnt;
  logic              r_ovf;
  state_e            r_state, w_state_next;
  state_e            r_tgt, w_tgt_next;
  logic              r_last_dir, w_last_dir_next;
  logic [BurstW-1:0] r_drain_cnt, w_drain_cnt_next;

  logic              w_pop, w_push_ok;
  logic [CntW-1:0]   w_cnt_after_pop;
  logic [EntW-1:0]   w_head;

  assign w_pop           = bus_valid && bus_ready;
  assign w_push_ok       = out_push && (!out_full || w_pop);
  assign w_cnt_after_pop = r_cnt - CntW'(w_pop);
  assign w_head          = r_mem[r_rptr];

  // Storage is not reset; entries are discarded by clearing the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= {out_data, out_ch, out_y, out_x};
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)     r_rptr <= r_rptr + PtrW'(1);
      r_cnt <= r_cnt + CntW'(w_push_ok) - CntW'(w_pop);
      if (out_push && !w_push_ok) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      r_state     <= StIdle;
      r_tgt       <= StLoad;
      r_last_dir  <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_tgt       <= w_tgt_next;
      r_last_dir  <= w_last_dir_next;
      r_drain_cnt <= w_drain_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_tgt_next       = r_tgt;
    w_last_dir_next  = r_last_dir;
    w_drain_cnt_next = r_drain_cnt;
    unique case (r_state)
      StIdle: begin
        if (ld_req && (r_cnt < AfullLvl)) begin
          if (!r_last_dir) begin
            w_state_next    = StLoad;
            w_last_dir_next = 1'b0;
          end else begin
            w_state_next = StTurn;
            w_tgt_next   = StLoad;
          end
        end else if (r_cnt != '0) begin
          if (r_last_dir) begin
            w_state_next     = StDrain;
            w_last_dir_next  = 1'b1;
            w_drain_cnt_next = '0;
          end else begin
            w_state_next = StTurn;
            w_tgt_next   = StDrain;
          end
        end
      end
      StLoad: begin
        if (!ld_req) begin
          w_state_next = StIdle;
        end else if (r_cnt >= AfullLvl) begin
          w_state_next = StTurn;
          w_tgt_next   = StDrain;
        end
      end
      StTurn: begin
        w_state_next     = r_tgt;
        w_last_dir_next  = (r_tgt == StDrain);
        w_drain_cnt_next = '0;
      end
      StDrain: begin
        // Saturates at the burst limit so a late ld_req still gets its turn.
        if (w_pop && (r_drain_cnt != BurstLast)) w_drain_cnt_next = r_drain_cnt + BurstW'(1);
        if (w_cnt_after_pop == '0) begin
          w_state_next = StIdle;
        end else if (ld_req && w_pop && (r_drain_cnt == BurstLast) &&
                     (w_cnt_after_pop < AfullLvl)) begin
          w_state_next = StTurn;
          w_tgt_next   = StLoad;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Grant is withdrawn as soon as the FIFO is almost full, ahead of the turnaround.
  always_comb begin
    ld_grant  = 1'b0;
    bus_valid = 1'b0;
    bus_dir   = r_last_dir;
    case (r_state)
      StLoad: begin
        ld_grant = (r_cnt < AfullLvl);
        bus_dir  = 1'b0;
      end
      StDrain: begin
        bus_valid = (r_cnt != '0);
        bus_dir   = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_full     = (r_cnt == FullLvl);
  assign overflow_err = r_ovf;
  assign bus_x        = w_head[31:0];
  assign bus_y        = w_head[63:32];
  assign bus_ch       = w_head[95:64];
  assign bus_data     = w_head[EntW-1:96];

endmodule

// File: tb/tb_cons_bus_arbiter.sv
// Bench for cons_bus_arbiter: directed arbitration/latency scenarios, then randomized traffic
// checked by a FIFO scoreboard and bus-protocol monitor sampling on the falling edge.
module tb_cons_bus_arbiter;

  localparam int unsigned Depth = 4;
  localparam int unsigned Dw    = 32;
  localparam int unsigned Burst = 2;

  logic          clk = 1'b0;
  logic          arst_n_in, ld_req, ld_grant, out_push, out_full;
  logic [31:0]   out_x, out_y, out_ch, bus_x, bus_y, bus_ch;
  logic [Dw-1:0] out_data, bus_data;
  logic          bus_valid, bus_ready, bus_dir, overflow_err;

  always #5 clk = ~clk;

  cons_bus_arbiter #(
    .FIFO_DEPTH(Depth),
    .DATA_WIDTH(Dw),
    .BURST_LEN (Burst)
  ) dut (
    .clk         (clk),
    .arst_n_in   (arst_n_in),
    .ld_req      (ld_req),
    .ld_grant    (ld_grant),
    .out_push    (out_push),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_ch      (out_ch),
    .out_data    (out_data),
    .out_full    (out_full),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_x       (bus_x),
    .bus_y       (bus_y),
    .bus_ch      (bus_ch),
    .bus_data    (bus_data),
    .bus_dir     (bus_dir),
    .overflow_err(overflow_err)
  );

  typedef struct {
    logic [31:0]   x;
    logic [31:0]   y;
    logic [31:0]   ch;
    logic [Dw-1:0] d;
  } desc_t;

  desc_t q[$];
  desc_t prev_head;
  logic  exp_ovf    = 1'b0;
  logic  prev_stall = 1'b0;
  logic  mon_en     = 1'b0;
  logic  mon_pop;
  int    mon_sz;
  int    n_checks   = 0;
  int    n_err      = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [31:0] x, input logic [31:0] y, input logic [31:0] ch,
                          input logic [Dw-1:0] d);
    out_push = 1'b1;
    out_x    = x;
    out_y    = y;
    out_ch   = ch;
    out_data = d;
  endtask

  task automatic push_rand();
    set_push($urandom, $urandom, $urandom, $urandom);
  endtask

  // Scoreboard: model FIFO of accepted descriptors, sticky overflow, and bus protocol rules.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_sz  = q.size();
      mon_pop = bus_valid && bus_ready;
      chk("out_full", out_full, 64'(mon_sz == Depth));
      chk("overflow_err", overflow_err, exp_ovf);
      chk("grant_valid_exclusive", ld_grant && bus_valid, 0);
      if (bus_valid) chk("dir_while_valid", bus_dir, 1);
      if (ld_grant)  chk("dir_while_grant", bus_dir, 0);
      if (prev_stall) begin
        chk("stall_valid", bus_valid, 1);
        chk("stall_x", bus_x, prev_head.x);
        chk("stall_y", bus_y, prev_head.y);
        chk("stall_ch", bus_ch, prev_head.ch);
        chk("stall_data", bus_data, prev_head.d);
      end
      prev_stall  = bus_valid && !bus_ready;
      prev_head.x = bus_x;
      prev_head.y = bus_y;
      prev_head.ch = bus_ch;
      prev_head.d = bus_data;
      if (mon_pop) begin
        chk("pop_from_empty", 64'(mon_sz == 0), 0);
        if (mon_sz != 0) begin
          chk("pop_x", bus_x, q[0].x);
          chk("pop_y", bus_y, q[0].y);
          chk("pop_ch", bus_ch, q[0].ch);
          chk("pop_data", bus_data, q[0].d);
          void'(q.pop_front());
        end
      end
      if (out_push && ((mon_sz < Depth) || mon_pop)) begin
        q.push_back('{x: out_x, y: out_y, ch: out_ch, d: out_data});
      end else if (out_push) begin
        exp_ovf = 1'b1;
      end
      if (!arst_n_in) begin
        q.delete();
        exp_ovf    = 1'b0;
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    desc_t s;
    arst_n_in = 1'b0;
    ld_req    = 1'b0;
    out_push  = 1'b0;
    out_x     = '0;
    out_y     = '0;
    out_ch    = '0;
    out_data  = '0;
    bus_ready = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();

    // Reset outputs, then a single load request.
    arst_n_in = 1'b1;
    ld_req    = 1'b1;
    chk("rst_grant", ld_grant, 0);
    chk("rst_valid", bus_valid, 0);
    chk("rst_dir", bus_dir, 0);
    chk("rst_full", out_full, 0);
    chk("rst_ovf", overflow_err, 0);
    tick();
    chk("load_grant", ld_grant, 1);
    chk("load_dir", bus_dir, 0);
    ld_req = 1'b0;
    tick();
    chk("load_release_grant", ld_grant, 0);

    // Single push with last direction = load: turnaround before drain.
    bus_ready = 1'b1;
    set_push(32'd2, 32'd5, 32'd1, 32'h1234);
    tick();
    out_push = 1'b0;
    chk("t1_valid", bus_valid, 0);
    tick();
    chk("turn_valid", bus_valid, 0);
    chk("turn_grant", ld_grant, 0);
    chk("turn_dir", bus_dir, 0);
    tick();
    chk("t3_valid", bus_valid, 1);
    chk("t3_x", bus_x, 2);
    chk("t3_y", bus_y, 5);
    chk("t3_ch", bus_ch, 1);
    chk("t3_data", bus_data, 32'h1234);
    chk("t3_dir", bus_dir, 1);
    tick();
    chk("t4_valid", bus_valid, 0);
    chk("t4_dir", bus_dir, 1);

    // Push with last direction = drain: no turnaround.
    push_rand();
    tick();
    out_push = 1'b0;
    chk("lat_t1_valid", bus_valid, 0);
    tick();
    chk("lat_t2_valid", bus_valid, 1);
    tick();
    chk("lat_t3_valid", bus_valid, 0);

    // Load interrupted by the FIFO becoming almost full.
    bus_ready = 1'b0;
    ld_req    = 1'b1;
    tick();
    chk("pre_load_turn_grant", ld_grant, 0);
    tick();
    chk("af_load_grant", ld_grant, 1);
    chk("af_load_dir", bus_dir, 0);
    for (int i = 0; i < 3; i++) begin
      push_rand();
      tick();
      chk("af_grant_by_count", ld_grant, 64'(i < 2));
    end
    out_push = 1'b0;
    tick();
    chk("af_turn_grant", ld_grant, 0);
    chk("af_turn_valid", bus_valid, 0);
    tick();
    chk("af_drain_valid", bus_valid, 1);
    chk("af_drain_dir", bus_dir, 1);
    chk("af_drain_grant", ld_grant, 0);

    // Back-pressure, glitch on reset between edges, overflow.
    ld_req    = 1'b0;
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    s.x = bus_x;
    s.d = bus_data;
    #1 arst_n_in = 1'b0;
    #1 arst_n_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", bus_valid, 1);
      chk("bp_x", bus_x, s.x);
      chk("bp_data", bus_data, s.d);
      chk("bp_full", out_full, 0);
    end
    push_rand();
    tick();
    push_rand();
    tick();
    chk("ovf_full", out_full, 1);
    chk("ovf_before", overflow_err, 0);
    push_rand();
    tick();
    out_push = 1'b0;
    chk("ovf_set", overflow_err, 1);
    chk("ovf_still_full", out_full, 1);
    tick();
    tick();
    chk("ovf_sticky", overflow_err, 1);

    // Reset in the middle of a drain with three entries.
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    chk("mid_drain_valid", bus_valid, 1);
    chk("mid_drain_full", out_full, 0);
    arst_n_in = 1'b0;
    tick();
    arst_n_in = 1'b1;
    chk("mrst_valid", bus_valid, 0);
    chk("mrst_full", out_full, 0);
    chk("mrst_ovf", overflow_err, 0);
    chk("mrst_grant", ld_grant, 0);
    chk("mrst_dir", bus_dir, 0);

    // Burst limit hands the bus back to a pending load.
    for (int i = 0; i < 3; i++) begin
      push_rand();
      tick();
    end
    out_push = 1'b0;
    chk("burst_drain_valid", bus_valid, 1);
    ld_req    = 1'b1;
    bus_ready = 1'b1;
    tick();
    chk("burst_second_valid", bus_valid, 1);
    tick();
    chk("burst_turn_valid", bus_valid, 0);
    chk("burst_turn_grant", ld_grant, 0);
    chk("burst_turn_dir", bus_dir, 1);
    bus_ready = 1'b0;
    tick();
    chk("burst_load_grant", ld_grant, 1);
    chk("burst_load_dir", bus_dir, 0);
    chk("burst_left_full", out_full, 0);
    ld_req = 1'b0;
    tick();
    chk("back_idle_grant", ld_grant, 0);
    tick();
    tick();
    chk("pp_drain_valid", bus_valid, 1);

    // Push and pop together leave the count unchanged: three more pushes fill it.
    bus_ready = 1'b1;
    push_rand();
    tick();
    bus_ready = 1'b0;
    push_rand();
    tick();
    push_rand();
    tick();
    chk("pp_count3_full", out_full, 0);
    push_rand();
    tick();
    out_push = 1'b0;
    chk("pp_count4_full", out_full, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      arst_n_in = ($urandom_range(0, 299) != 0);
      ld_req    = ($urandom_range(0, 9) < 4);
      bus_ready = ($urandom_range(0, 9) < 7);
      out_push  = ($urandom_range(0, 1) == 1);
      out_x     = $urandom;
      out_y     = $urandom;
      out_ch    = $urandom;
      out_data  = $urandom;
      tick();
    end

    // Bounded final drain.
    arst_n_in = 1'b1;
    out_push  = 1'b0;
    ld_req    = 1'b0;
    bus_ready = 1'b1;
    for (int i = 0; i < 64 && q.size() != 0; i++) tick();
    chk("final_drain_empty", q.size(), 0);
    tick();
    tick();
    chk("final_valid_low", bus_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/cons_bus_arbiter.md
CONS_BUS_ARBITER -- requirements
Module: cons_bus_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, output-descriptor FIFO entries (power of two, >=2).
REQ-002 Parameter: DATA_WIDTH, default 32, output data word width.
REQ-003 Parameter: BURST_LEN, default 3, max drain transfers per grant while a load is pending (>=1).
REQ-004 Port: clk  in  1  single clock; all state on rising edge.
REQ-005 Port: arst_n_in  in  1  reset, synchronous, active-low.
REQ-006 Port: ld_req  in  1  controller requests the shared bus host->device (kernel/input loading).
REQ-007 Port: ld_grant  out  1  bus currently owned by load path.
REQ-008 Port: out_push  in  1  controller presents one output descriptor.
REQ-009 Port: out_x, out_y, out_ch  in  32 each  output coordinates.
REQ-010 Port: out_data  in  DATA_WIDTH  output value.
REQ-011 Port: out_full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-012 Port: bus_valid  out  1  device->host descriptor valid on bus.
REQ-013 Port: bus_ready  in  1  host accepts descriptor.
REQ-014 Port: bus_x, bus_y, bus_ch  out  32 each; bus_data  out  DATA_WIDTH  FIFO head contents.
REQ-015 Port: bus_dir  out  1  0 = host->device, 1 = device->host.
REQ-016 Port: overflow_err  out  1  sticky, push attempted while full.

Function
REQ-017 FIFO SHALL be circular, FIFO_DEPTH entries, count width clog2(FIFO_DEPTH)+1; bus_* SHALL show head entry combinationally from storage.
REQ-018 Push SHALL be accepted when out_push and (!out_full or pop in same cycle); pop = bus_valid && bus_ready.
REQ-019 Simultaneous accepted push and pop SHALL leave count unchanged; pointers both advance, wrap modulo FIFO_DEPTH.
REQ-020 Push while full without same-cycle pop SHALL be dropped and set overflow_err until reset.
REQ-021 FSM states: IDLE, LOAD, TURN, DRAIN; register last_dir records direction of last LOAD/DRAIN.
REQ-022 IDLE: if ld_req and count<FIFO_DEPTH-1 -> LOAD (last_dir=0) else TURN; else if count>0 -> DRAIN (last_dir=1) else TURN; else stay.
REQ-023 TURN SHALL last exactly one cycle, then enter the target state chosen when TURN was entered (register tgt).
REQ-024 LOAD: ld_grant=1; ld_req low -> IDLE; count>=FIFO_DEPTH-1 -> TURN (tgt DRAIN); else stay.
REQ-025 DRAIN: bus_valid=(count>0); drain_cnt increments per pop, cleared on DRAIN entry.
REQ-026 DRAIN exit: count becomes 0 after pop (or is 0) -> IDLE; ld_req and pop with drain_cnt==BURST_LEN-1 and count after pop <FIFO_DEPTH-1 -> TURN (tgt LOAD); else stay.
REQ-027 Almost-full priority: DRAIN SHALL ignore BURST_LEN limit while count after pop >= FIFO_DEPTH-1.
REQ-028 bus_dir SHALL equal 0 in LOAD, 1 in DRAIN, last_dir in IDLE/TURN.
REQ-029 ld_grant and bus_valid SHALL both be 0 in IDLE and TURN; never both 1.
REQ-030 Latency: push into empty FIFO at cycle t with last_dir=1 and ld_req low SHALL give bus_valid at t+2; with last_dir=0, at t+3.
REQ-031 bus_* SHALL hold stable while bus_valid && !bus_ready.

Reset
REQ-032 arst_n_in low at a clock edge SHALL set state IDLE, count/pointers 0, last_dir 0, tgt LOAD, drain_cnt 0, overflow_err 0.
REQ-033 Outputs after reset: ld_grant 0, bus_valid 0, bus_dir 0, out_full 0, overflow_err 0; FIFO contents discarded, including mid-DRAIN/mid-LOAD reset.
REQ-034 Reset SHALL be synchronous only; a reset pulse between edges SHALL have no effect.

Verification
REQ-035 Reset, ld_req=1 -> cycle 1 LOAD, ld_grant=1, bus_dir=0; ld_req=0 -> IDLE next cycle.
REQ-036 ld_req=0, push (x=2,y=5,ch=1,data=0x1234) at t, bus_ready=1 -> TURN at t+2, bus_valid at t+3 with same values, IDLE at t+4, bus_dir=1.
REQ-037 FIFO_DEPTH=4 during LOAD, 3 pushes -> TURN then DRAIN though ld_req=1; ld_grant=0 from the cycle count reaches 3.
REQ-038 DRAIN with 2 entries, bus_ready=0 for 5 cycles -> bus_* stable, count 2; push when full -> dropped, overflow_err=1, stays 1.
REQ-039 DRAIN, ld_req=1, 3 entries, bus_ready=1, BURST_LEN=2 -> 2 pops, TURN, LOAD; 1 entry remains; push+pop same cycle keeps count.
REQ-040 Reset asserted mid-DRAIN with 3 entries -> next cycle count 0, bus_valid 0, state IDLE.
